fifo_flex: RTL
==============

# fifo_flex

Next-generation parametrised synchronous FIFO for the datapath buffering layer. Supports any integer depth (not only powers of two), selectable standard or first-word-fall-through read mode, programmable almost-full/almost-empty thresholds and sticky overflow/underflow error flags. Drop-in buffering between producer and consumer stages on a single clock domain.

## Interface
- DATA_WIDTH, 32, entry width in bits (≥1)
- DEPTH, 8, number of entries; any integer ≥2
- MODE, FIFO_STD, read mode: FIFO_STD (registered read data) or FIFO_FWFT (head visible without pop)
- AFULL_THRESH, DEPTH-1, almost_full_o asserts when occupancy ≥ this (1..DEPTH)
- AEMPTY_THRESH, 1, almost_empty_o asserts when occupancy ≤ this (0..DEPTH-1)
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-high reset
- push_i  input  1  write request
- wr_data_i  input  DATA_WIDTH  write data
- pop_i  input  1  read request
- clr_err_i  input  1  clears sticky error flags
- rd_data_o  output  DATA_WIDTH  read data
- rd_valid_o  output  1  rd_data_o holds valid data
- full_o / empty_o  output  1  occupancy == DEPTH / == 0
- almost_full_o / almost_empty_o  output  1  threshold flags
- occupancy_o  output  CNT_W = $clog2(DEPTH+1)  current entry count
- overflow_o / underflow_o  output  1  sticky error flags

## Operation
- push accepted iff push_i && !full_o; pop accepted iff pop_i && !empty_o. Flags taken from registered state at start of cycle.
- Push on full: data dropped, state unchanged, overflow_o set next cycle. Pop on empty: no state change, underflow_o set next cycle.
- Simultaneous accepted push+pop: occupancy unchanged, both pointers advance.
- Pointers are 0..DEPTH-1 and wrap from DEPTH-1 to 0 (explicit compare, not bit overflow). Occupancy counts 0..DEPTH in CNT_W bits; never wraps.
- FIFO_STD: accepted pop loads head entry into rd_data_o register; rd_valid_o is a one-cycle pulse the cycle after the pop. rd_data_o holds last popped value otherwise.
- FIFO_FWFT: rd_data_o = head entry, rd_valid_o = !empty_o; pop consumes head, next entry visible following cycle. rd_data_o forced to 0 when empty.
- almost_full_o = occupancy ≥ AFULL_THRESH; almost_empty_o = occupancy ≤ AEMPTY_THRESH.
- Error flags: set on event, cleared by clr_err_i; a set event in the same cycle as clr_err_i wins.
- Storage array is not reset; contents after reset are don't-care and never visible.

## Timing
- Reset values: occupancy_o 0, empty_o 1, full_o 0, almost_empty_o 1, almost_full_o 0, rd_valid_o 0, rd_data_o 0, overflow_o 0, underflow_o 0; pointers 0.
- Reset mid-operation clears all state immediately (asynchronous); stored entries are lost.
- All flags and occupancy_o update the cycle after the accepted push/pop edge.
- Write-to-read latency: FWFT, data pushed into empty FIFO visible on rd_data_o 1 cycle after push edge; STD, pop may be issued that cycle, data appears 1 cycle after pop.
- Full throughput: one push and one pop per cycle sustained.

## Structure
- Package fifo_pkg: typedef enum fifo_mode_e {FIFO_STD, FIFO_FWFT}; shared by all FIFO variants.
- Sub-module fifo_ptr: wrapping pointer with enable, parameter DEPTH, instantiated for read and write pointers.
- Parameter legality (thresholds in range, DEPTH ≥2) checked with elaboration-time assertions.

## Test plan
- Reset then idle, DEPTH=5, DATA_WIDTH=8 -> empty_o=1, almost_empty_o=1, occupancy_o=0, all other outputs 0.
- STD: push 0x11..0x15 -> full_o=1, almost_full_o=1 at occupancy 4; sixth push 0x16 -> overflow_o=1, occupancy stays 5; five pops -> rd_data_o 0x11..0x15 each with rd_valid_o pulse one cycle after pop.
- Wrap: DEPTH=5, 12 push/pop pairs of incrementing data at occupancy 2 -> output order exact, occupancy constant 2, pointers wrap at 4.
- FWFT: push 0xA5 into empty -> next cycle rd_valid_o=1, rd_data_o=0xA5 without pop; pop -> empty_o=1, rd_data_o=0.
- Pop on empty -> underflow_o=1; assert clr_err_i same cycle as another empty pop -> underflow_o remains 1; clr_err_i alone -> 0.
- Reset asserted mid-stream at occupancy 3 -> all outputs return to reset values asynchronously; subsequent push/pop sequence correct.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types for the FIFO family: read-mode selector and width helpers.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package fifo_pkg;

    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    // Pointer width for a 0..depth-1 index; a depth of 1 still needs one bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping index 0..DEPTH-1 that advances on en, for non power-of-two depths.
// Latency: new value visible the cycle after en.
// Backpressure: none; the caller gates en.
module fifo_ptr
    import fifo_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int PTR_W = ptr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [PTR_W-1:0] ptr
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (en) begin
            // Explicit wrap: DEPTH need not be a power of two.
            ptr <= (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_flex.sv
// Single-clock FIFO, any depth, STD or FWFT read, threshold and sticky error flags.
// Latency: FWFT head visible 1 cycle after push; STD data 1 cycle after pop.
// Backpressure: push dropped when full (overflow), pop ignored when empty (underflow).
module fifo_flex
    import fifo_pkg::*;
#(
    parameter int         DATA_WIDTH    = 32,
    parameter int         DEPTH         = 8,
    parameter fifo_mode_e MODE          = FIFO_STD,
    parameter int         AFULL_THRESH  = DEPTH - 1,
    parameter int         AEMPTY_THRESH = 1,
    localparam int        CNT_W         = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  pop_i,
    input  logic                  clr_err_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  rd_valid_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  almost_full_o,
    output logic                  almost_empty_o,
    output logic [CNT_W-1:0]      occupancy_o,
    output logic                  overflow_o,
    output logic                  underflow_o
);

    localparam int PTR_W = ptr_width(DEPTH);

    if (DEPTH < 2) begin : g_bad_depth
        $error("fifo_flex: DEPTH must be >= 2");
    end
    if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
        $error("fifo_flex: AFULL_THRESH must be in 1..DEPTH");
    end
    if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1) begin : g_bad_aempty
        $error("fifo_flex: AEMPTY_THRESH must be in 0..DEPTH-1");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  do_push;
    logic                  do_pop;

    assign full_o         = (count == CNT_W'(DEPTH));
    assign empty_o        = (count == '0);
    assign almost_full_o  = (count >= CNT_W'(AFULL_THRESH));
    assign almost_empty_o = (count <= CNT_W'(AEMPTY_THRESH));
    assign occupancy_o    = count;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .en    (do_push),
        .ptr   (wr_ptr)
    );

    fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .en    (do_pop),
        .ptr   (rd_ptr)
    );

    // Storage is deliberately unreset; empty gating keeps stale words hidden.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else begin
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // A new error event outranks a clear in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            if (push_i && full_o)     overflow_o <= 1'b1;
            else if (clr_err_i)       overflow_o <= 1'b0;
            if (pop_i && empty_o)     underflow_o <= 1'b1;
            else if (clr_err_i)       underflow_o <= 1'b0;
        end
    end

    if (MODE == FIFO_FWFT) begin : g_fwft
        assign rd_data_o  = empty_o ? '0 : mem[rd_ptr];
        assign rd_valid_o = !empty_o;
    end else begin : g_std
        logic [DATA_WIDTH-1:0] rd_data_q;
        logic                  rd_valid_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                rd_valid_q <= do_pop;
                if (do_pop) begin
                    rd_data_q <= mem[rd_ptr];
                end
            end
        end

        assign rd_data_o  = rd_data_q;
        assign rd_valid_o = rd_valid_q;
    end

endmodule
